// File: rtl/fp_mul_pipe_pkg.sv
// Shared definitions for the floating-point datapath blocks: operand class
// encoding, exception flag bit positions and format derivation helpers.
package fp_mul_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_classify.sv
// Combinational operand classifier: splits one operand into sign, class and
// mantissa with the hidden bit restored. Denormals are flushed to zero.
module fp_classify
  import fp_mul_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output fp_class_e            cls,
  output logic [MAN_W:0]       mant
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  assign sign   = op[EXP_W+MAN_W];
  assign exp_f  = op[MAN_W +: EXP_W];
  assign frac_f = op[MAN_W-1:0];

  always_comb begin
    cls  = CLS_NORM;
    mant = {1'b1, frac_f};
    if (exp_f == '0) begin
      cls  = CLS_ZERO;
      mant = '0;
    end else if (&exp_f) begin
      cls  = (frac_f == '0) ? CLS_INF : CLS_NAN;
      mant = '0;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with round-to-nearest-even,
// FTZ special handling, exception flags and a valid/ready stream interface.
module fp_mul_pipe
  import fp_mul_pipe_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_flags
);

  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam int EMAX = fp_emax(EXP_W);

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. The whole pipe moves as one unit; it freezes only when a result
  // sits on the output and the consumer refuses it, and in_ready mirrors that.
  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // ---------------- S1: classify, sign, exponent sum, mantissa product
  logic             sign_a, sign_b;
  fp_class_e        cls_a, cls_b;
  logic [MAN_W:0]   mant_a, mant_b;
  logic signed [EW-1:0] exp_sum;
  logic [PW-1:0]    prod;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op   (in_a),
    .sign (sign_a),
    .cls  (cls_a),
    .mant (mant_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op   (in_b),
    .sign (sign_b),
    .cls  (cls_b),
    .mant (mant_b)
  );

  // Two extra bits keep the biased sum and its later increments from wrapping
  assign exp_sum = $signed({2'b00, in_a[MAN_W +: EXP_W]})
                 + $signed({2'b00, in_b[MAN_W +: EXP_W]}) - BIAS_E;
  assign prod    = PW'(mant_a) * PW'(mant_b);

  logic                 s1_valid;
  logic                 s1_sign;
  fp_class_e            s1_cls_a, s1_cls_b;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= sign_a ^ sign_b;
      s1_cls_a <= cls_a;
      s1_cls_b <= cls_b;
      s1_exp   <= exp_sum;
      s1_prod  <= prod;
    end
  end

  // ---------------- S2: normalise and round to nearest even
  logic signed [EW-1:0] norm_exp, rnd_exp;
  logic [MAN_W-1:0]     kept, rnd_frac;
  logic [MAN_W:0]       rounded;
  logic                 guard, sticky, round_up;

  always_comb begin
    norm_exp = s1_exp;
    kept     = s1_prod[2*MAN_W-1 -: MAN_W];
    guard    = s1_prod[MAN_W-1];
    sticky   = |s1_prod[MAN_W-2:0];
    if (s1_prod[PW-1]) begin
      norm_exp = s1_exp + ONE_E;
      kept     = s1_prod[2*MAN_W -: MAN_W];
      guard    = s1_prod[MAN_W];
      sticky   = |s1_prod[MAN_W-1:0];
    end
    round_up = guard && (sticky || kept[0]);
    rounded  = {1'b0, kept} + {{MAN_W{1'b0}}, round_up};
    rnd_frac = rounded[MAN_W-1:0];
    rnd_exp  = norm_exp;
    // Carry-out leaves the fraction at zero; only the exponent moves
    if (rounded[MAN_W]) begin
      rnd_exp = norm_exp + ONE_E;
    end
  end

  logic                 s2_valid;
  logic                 s2_sign;
  fp_class_e            s2_cls_a, s2_cls_b;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_frac;
  logic                 s2_inexact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_cls_a   <= CLS_ZERO;
      s2_cls_b   <= CLS_ZERO;
      s2_exp     <= '0;
      s2_frac    <= '0;
      s2_inexact <= 1'b0;
    end else if (advance) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_cls_a   <= s1_cls_a;
      s2_cls_b   <= s1_cls_b;
      s2_exp     <= rnd_exp;
      s2_frac    <= rnd_frac;
      s2_inexact <= guard || sticky;
    end
  end

  // ---------------- S3: special-value select, pack, flags
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;
  logic         any_nan, any_inf, any_zero, inf_times_zero;

  assign any_nan  = (s2_cls_a == CLS_NAN)  || (s2_cls_b == CLS_NAN);
  assign any_inf  = (s2_cls_a == CLS_INF)  || (s2_cls_b == CLS_INF);
  assign any_zero = (s2_cls_a == CLS_ZERO) || (s2_cls_b == CLS_ZERO);
  assign inf_times_zero = any_inf && any_zero;

  always_comb begin
    res_data  = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    res_flags = '0;
    res_flags[FLAG_INEXACT] = s2_inexact;
    if (any_nan) begin
      res_data  = QNAN;
      res_flags = '0;
    end else if (inf_times_zero) begin
      res_data  = QNAN;
      res_flags = '0;
      res_flags[FLAG_INVALID] = 1'b1;
    end else if (any_inf) begin
      res_data  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = '0;
    end else if (any_zero) begin
      res_data  = {s2_sign, {(W-1){1'b0}}};
      res_flags = '0;
    end else if (s2_exp >= EMAX_E) begin
      res_data  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = '0;
      res_flags[FLAG_OVERFLOW] = 1'b1;
      res_flags[FLAG_INEXACT]  = 1'b1;
    end else if (s2_exp <= ZERO_E) begin
      res_data  = {s2_sign, {(W-1){1'b0}}};
      res_flags = '0;
      res_flags[FLAG_UNDERFLOW] = 1'b1;
      res_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

  // Bubbles load zeros so flags never show outside a valid result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      out_data  <= s2_valid ? res_data : '0;
      out_flags <= s2_valid ? res_flags : 4'h0;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: vector table replayed under several output
// backpressure patterns, plus latency, stall and reset sequences.
module tb_fp_mul_pipe;

  localparam int W  = 32;
  localparam int EW = W + 4;
  localparam int NV = 20;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic [3:0]   f;
  } vec_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [3:0]   out_flags;

  logic [EW-1:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int stall_cnt = 0;
  vec_t vecs[NV];

  fp_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- driver
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [EW-1:0] e);
    int waits = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("accept_timeout", EW'(in_ready), EW'(1));
    if (in_ready) exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive_vec(input int i);
    drive_op(vecs[i].a, vecs[i].b, {vecs[i].d, vecs[i].f});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", EW'(exp_q.size()), EW'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic latency_op(input int i);
    int start;
    int n = 0;
    start = cyc;
    drive_vec(i);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", EW'(cyc - start), EW'(3));
  endtask

  // ---------------- scoreboard / monitor
  task automatic monitor();
    logic          stalled = 1'b0;
    logic [EW-1:0] held    = '0;
    logic [EW-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        check("ready_rule", EW'(in_ready), EW'(!(out_valid && !out_ready)));
        if (!out_valid) check("idle_flags", EW'(out_flags), EW'(0));
        if (stalled && out_valid) check("stall_hold", {out_data, out_flags}, held);
        if (out_valid && !out_ready) stall_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h required no output", {out_data, out_flags});
          end else begin
            exp_v = exp_q.pop_front();
            check("result", {out_data, out_flags}, exp_v);
          end
        end
        stalled = out_valid && !out_ready;
        held    = {out_data, out_flags};
      end
    end
  endtask

  // ---------------- test sequence
  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1};
    vecs[2]  = '{32'h3F800001, 32'h3F800000, 32'h3F800001, 4'h0};
    vecs[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5};
    vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'h3};
    vecs[5]  = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 4'h8};
    vecs[6]  = '{32'h80000000, 32'h40400000, 32'h80000000, 4'h0};
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0};
    vecs[8]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0};
    vecs[9]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0};
    vecs[10] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1};
    vecs[11] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1};
    vecs[12] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'h1};
    vecs[13] = '{32'hFF000000, 32'h40000000, 32'hFF800000, 4'h5};
    vecs[14] = '{32'h80800000, 32'h3F000000, 32'h80000000, 4'h3};
    vecs[15] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'h0};
    vecs[16] = '{32'hFF800001, 32'h7F800000, 32'h7FC00000, 4'h0};
    vecs[17] = '{32'h00000001, 32'h40000000, 32'h00000000, 4'h0};
    vecs[18] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'h0};
    vecs[19] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h8};

    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", EW'(out_valid), EW'(0));
    check("rst_data", EW'(out_data), EW'(0));
    check("rst_flags", EW'(out_flags), EW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", EW'(in_ready), EW'(1));

    // single op latency on an empty pipe
    latency_op(0);
    drain();

    // whole table back-to-back, consumer always ready
    for (int i = 0; i < NV; i++) drive_vec(i);
    drain();

    // whole table again under random backpressure
    fork
      begin
        for (int i = 0; i < NV; i++) drive_vec(i);
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // six ops back-to-back with a five-cycle consumer stall mid-stream
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_vec(i);
      end
      begin
        int n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", EW'(stall_cnt), EW'(5));

    // reset pulse with one result on the output and another in flight
    drive_vec(0);
    drive_vec(8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", EW'(out_valid), EW'(0));
    check("midrst_data", EW'(out_data), EW'(0));
    check("midrst_flags", EW'(out_flags), EW'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_idle", EW'(out_valid), EW'(0));
    end
    latency_op(1);
    drain();

    check("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
